// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / timebase: per-channel tick strobe,
// square-wave output and one-shot completion flag from a single system clock.
module clk_div_multi #(
  parameter int                        NUM_CH   = 3,
  parameter int                        CNT_W    = 28,
  parameter int                        CH_W     = 2,
  parameter logic [NUM_CH*CNT_W-1:0]   DEF_HALF = {28'd125000000, 28'd50000000, 28'd10000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_val,
  output logic              load_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] done
);

  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  active [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] reload;
  logic              load_ok;

  always_comb begin
    load_ok = load && (32'(load_ch) < NUM_CH) && (load_val != '0);
    running = '0;
    tc      = '0;
    sel     = '0;
    reload  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      running[i] = en[i] && !(mode[i] && done[i]);
      tc[i]      = running[i] && (cnt[i] == active[i] - CNT_W'(1));
      sel[i]     = load_ok && (32'(load_ch) == i);
      // active only changes at a phase boundary (a real tick) or while idle,
      // so a running half-period always completes with the value it began with.
      reload[i]  = (tc[i] && !sync_clr) || !running[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
      tick     <= '0;
      clk_out  <= '0;
      done     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        active[i] <= DEF_HALF[i*CNT_W +: CNT_W];
        shadow[i] <= DEF_HALF[i*CNT_W +: CNT_W];
      end
    end else begin
      load_err <= load && !load_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel[i]) shadow[i] <= load_val;
        // A load landing on the reload edge bypasses the shadow register.
        if (reload[i]) active[i] <= sel[i] ? load_val : shadow[i];

        if (!en[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          done[i]    <= 1'b0;
        end else if (sync_clr) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (tc[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          if (mode[i]) done[i] <= 1'b1;
          else         clk_out[i] <= ~clk_out[i];
        end else if (running[i]) begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi: one task per scenario with
// hand-computed tick/clk_out/done/load_err expectations.
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 28;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic              sync_clr;
  logic              load;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_val;
  logic              load_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sync_clr (sync_clr),
    .load     (load),
    .load_ch  (load_ch),
    .load_val (load_val),
    .load_err (load_err),
    .tick     (tick),
    .clk_out  (clk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] val);
    load     = 1'b1;
    load_ch  = ch;
    load_val = val;
    step();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; mode = '0; sync_clr = 1'b0;
    load = 1'b0; load_ch = '0; load_val = '0;
    step();
    step();
    total_cnt++;
    if ({tick, clk_out, done, load_err} !== 10'b0)
      $display("FAIL reset_outputs got=%b required=0", {tick, clk_out, done, load_err});
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({tick, clk_out, done, load_err} !== 10'b0)
      $display("FAIL post_reset_idle got=%b required=0", {tick, clk_out, done, load_err});
    else pass_cnt++;
  endtask

  task automatic test_periodic();
    logic exp_tick;
    logic exp_clk;
    do_load(2'd0, 28'd4);
    en = 3'b001;
    for (int c = 1; c <= 24; c++) begin
      step();
      exp_tick = (c % 4 == 0);
      exp_clk  = ((c / 4) % 2 == 1);
      total_cnt++;
      if (tick[0] !== exp_tick || clk_out[0] !== exp_clk || tick[2:1] !== 2'b00 || clk_out[2:1] !== 2'b00)
        $display("FAIL periodic c=%0d tick=%b clk_out=%b required tick0=%b clk0=%b others=0",
                 c, tick, clk_out, exp_tick, exp_clk);
      else pass_cnt++;
    end
    en = '0;
    step();
  endtask

  task automatic test_min_half();
    do_load(2'd1, 28'd1);
    en = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      if (c == 7) do_load_nowait_zero();
      if (c == 8) load = 1'b0;
      step();
      total_cnt++;
      if (tick[1] !== 1'b1 || clk_out[1] !== (c % 2 == 1) || load_err !== (c == 7))
        $display("FAIL min_half c=%0d tick1=%b clk1=%b load_err=%b required 1/%b/%b",
                 c, tick[1], clk_out[1], load_err, (c % 2 == 1), (c == 7));
      else pass_cnt++;
    end
    en = '0;
    step();
  endtask

  task automatic do_load_nowait_zero();
    load     = 1'b1;
    load_ch  = 2'd1;
    load_val = '0;
  endtask

  task automatic test_reload();
    logic exp_tick;
    do_load(2'd0, 28'd10);
    en = 3'b001;
    for (int c = 1; c <= 23; c++) begin
      if (c == 6)  begin load = 1'b1; load_ch = 2'd0; load_val = 28'd3; end
      if (c == 7)  load = 1'b0;
      if (c == 19) begin load = 1'b1; load_ch = 2'd0; load_val = 28'd2; end
      if (c == 20) load = 1'b0;
      step();
      exp_tick = (c == 10 || c == 13 || c == 16 || c == 19 || c == 21 || c == 23);
      total_cnt++;
      if (tick[0] !== exp_tick)
        $display("FAIL reload c=%0d tick0=%b required=%b", c, tick[0], exp_tick);
      else pass_cnt++;
    end
    en = '0;
    step();
  endtask

  task automatic test_oneshot();
    do_load(2'd2, 28'd6);
    mode = 3'b100;
    for (int pass = 0; pass < 2; pass++) begin
      en = 3'b100;
      for (int c = 1; c <= 14; c++) begin
        step();
        total_cnt++;
        if (tick[2] !== (c == 6) || done[2] !== (c >= 6) || clk_out[2] !== 1'b0)
          $display("FAIL oneshot pass=%0d c=%0d tick2=%b done2=%b clk2=%b required %b/%b/0",
                   pass, c, tick[2], done[2], clk_out[2], (c == 6), (c >= 6));
        else pass_cnt++;
      end
      en = '0;
      step();
      total_cnt++;
      if (done[2] !== 1'b0 || tick[2] !== 1'b0)
        $display("FAIL oneshot_rearm pass=%0d done2=%b tick2=%b required 0/0", pass, done[2], tick[2]);
      else pass_cnt++;
    end
    mode = '0;
  endtask

  task automatic test_sync_clr();
    do_load(2'd0, 28'd4);
    do_load(2'd1, 28'd6);
    en = 3'b011;
    for (int c = 1; c <= 7; c++) step();
    // ch0 would reach its terminal count on this edge.
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    total_cnt++;
    if (tick !== 3'b000 || clk_out !== 3'b000)
      $display("FAIL sync_clr_edge tick=%b clk_out=%b required 000/000", tick, clk_out);
    else pass_cnt++;
    for (int c = 1; c <= 28; c++) begin
      step();
      total_cnt++;
      if (tick[1:0] !== {c % 6 == 0, c % 4 == 0} ||
          clk_out[1:0] !== {(c / 6) % 2 == 1, (c / 4) % 2 == 1})
        $display("FAIL sync_align c=%0d tick=%b clk_out=%b required tick=%b clk=%b",
                 c, tick[1:0], clk_out[1:0], {c % 6 == 0, c % 4 == 0},
                 {(c / 6) % 2 == 1, (c / 4) % 2 == 1});
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int first;
    // clk_out[0] is high here (left running by the alignment scenario).
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if ({tick, clk_out, done, load_err} !== 10'b0)
      $display("FAIL async_reset got=%b required=0", {tick, clk_out, done, load_err});
    else pass_cnt++;
    en = '0;
    step();
    rst = 1'b0;
    en  = 3'b001;
    first = -1;
    for (int c = 1; c <= 10100 && first < 0; c++) begin
      step();
      if (tick[0] === 1'b1) first = c;
    end
    total_cnt++;
    if (first !== 10000)
      $display("FAIL default_first_tick got=%0d required=10000", first);
    else pass_cnt++;
    en = '0;
    step();
    do_load(2'd3, 28'd5);
    total_cnt++;
    if (load_err !== 1'b1)
      $display("FAIL bad_channel_load load_err=%b required=1", load_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (load_err !== 1'b0)
      $display("FAIL load_err_pulse load_err=%b required=0", load_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_min_half();
    test_reload();
    test_oneshot();
    test_sync_clr();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised N-channel clock divider / timebase generator; successor to the fixed three-output divider used for display scan, seconds countdown and buzzer.
- Each channel has a runtime-programmable half-period, enable, periodic or one-shot mode, a single-cycle tick strobe and a square-wave output.
- Sits beside the top-level controller and feeds the display, timer and buzzer logic from the single system clock.

Parameters:
- NUM_CH, 3, number of channels (1..8).
- CNT_W, 28, counter and half-period width in bits.
- CH_W, 2, width of load_ch; must be at least max(1, clog2(NUM_CH)).
- DEF_HALF, {28'd125000000, 28'd50000000, 28'd10000}, flattened NUM_CH*CNT_W reset half-periods; channel i occupies bits [i*CNT_W +: CNT_W].

Ports:
- clk  in  1  system clock (100 MHz); all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- mode  in  NUM_CH  per-channel mode: 0 = periodic, 1 = one-shot.
- sync_clr  in  1  clears all channel counters and outputs together (phase alignment).
- load  in  1  write strobe for a half-period value.
- load_ch  in  CH_W  channel selected by load.
- load_val  in  CNT_W  new half-period, in clk cycles.
- load_err  out  1  one-cycle pulse when a load is rejected.
- tick  out  NUM_CH  one-cycle strobe at each terminal count.
- clk_out  out  NUM_CH  divided square wave, toggles on each periodic tick.
- done  out  NUM_CH  sticky one-shot completion flag.

Behaviour:
- Reset values (asynchronous):
  - cnt = 0, tick = 0, clk_out = 0, done = 0, load_err = 0.
  - shadow[i] = active[i] = DEF_HALF[i].
- Terminal count (TC): channel i is running and cnt[i] == active[i] - 1.
- Running: en[i] = 1 and not (mode[i] = 1 and done[i] = 1).
- Running channel, not at TC: cnt increments by 1.
- Running channel at TC:
  - cnt <= 0 and tick[i] pulses for exactly 1 cycle.
  - Periodic mode: clk_out[i] toggles, giving a period of 2*active[i] cycles.
  - One-shot mode: done[i] <= 1, clk_out[i] unchanged (stays 0); the channel stops.
- Latency: with en rising at edge 0 from cnt = 0, the first tick is high after edge active[i] (registered, no combinational path from en).
- en[i] = 0: cnt <= 0, clk_out[i] <= 0, tick[i] <= 0, done[i] <= 0. A one-shot channel is re-armed only by deasserting en.
- mode change while running takes effect at the next edge; cnt is not cleared.
- Half-period 1: periodic mode ticks every cycle and clk_out = clk/2.
- Load acceptance: accepted when load = 1, load_ch < NUM_CH and load_val != 0; the value is written to shadow[load_ch].
- Load rejection: otherwise load_err pulses 1 cycle and no state changes.
- active[i] is updated from shadow[i]:
  - at a TC edge, or
  - on every edge while the channel is not running.
- Load on the same edge as a TC of that channel: load_val bypasses into active directly.
- Load while running: the current half-period completes with the old value; no truncated or stretched phase.
- sync_clr = 1 clears cnt, clk_out and tick of all channels on that edge.
  - It overrides TC: no tick and no toggle that cycle.
  - done and the shadow/active values are unaffected.
- Counter arithmetic is modulo active; cnt never exceeds active - 1.
- active is never 0, because a zero load is rejected; DEF_HALF entries must be nonzero.
- rst asserted mid-operation: all outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Periodic half-period: rst released, en = 3'b001, ch0 loaded with 4 -> tick[0] at cycles 4, 8, 12…; clk_out[0] period 8 cycles, 50% duty; other channels stay 0.
- Minimum half-period and zero load: load ch1 = 1, en[1] = 1 -> tick[1] high every cycle and clk_out[1] = clk/2. Then load_val = 0 -> load_err pulses once and the ch1 waveform is unchanged.
- Mid-period reload: ch0 running with half-period 10, load 3 at cnt = 5 -> the next tick comes 5 cycles later, then every 3. A load coinciding with TC makes the new value effective immediately.
- One-shot: mode[2] = 1, half-period 6, en[2] rises -> a single tick[2] at cycle 6, done[2] = 1 and stays high with no further ticks. en[2] low for 1 cycle, then high -> a fresh tick 6 cycles later.
- Phase alignment: ch0 (half-period 4) and ch1 (half-period 6) running; pulse sync_clr at an arbitrary cycle -> both cnt = 0 and clk_out = 0. Their ticks then coincide every 12 cycles, and no tick occurs in the sync_clr cycle.
- Async reset: assert rst between clock edges mid-run -> outputs are 0 before the next edge. After release, defaults apply: ch0 first tick at cycle 10000, and load_ch = 3 raises load_err.
